// File: rtl/aemb2_mul_pkg.sv
// Shared definitions for the AEMB2 multiplier: function codes, iterative FSM
// states and the operand sign-extension rule.
package aemb2_mul_pkg;

  localparam logic [1:0] MUL_LO  = 2'b00;
  localparam logic [1:0] MUL_HSS = 2'b01;
  localparam logic [1:0] MUL_HSU = 2'b10;
  localparam logic [1:0] MUL_HUU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mul_state_e;

  // opsel 0 selects operand A, 1 selects operand B
  function automatic logic ext_sign(input logic [1:0] fn, input logic opsel);
    logic r;
    case (fn)
      MUL_HSS: r = 1'b1;
      MUL_HSU: r = ~opsel;
      MUL_LO:  r = 1'b0;
      MUL_HUU: r = 1'b0;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aemb2_mulx_iter.sv
// Iterative shift-add multiplier: sign-magnitude, one multiplier bit per
// enabled cycle, result valid DW+3 enabled cycles after the strobe.
module aemb2_mulx_iter
  import aemb2_mul_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          gclk,
  input  logic          grst,
  input  logic          dena,
  input  logic          gpha,
  input  logic          mul_stb,
  input  logic [1:0]    mul_fn,
  input  logic [DW-1:0] opa_of,
  input  logic [DW-1:0] opb_of,
  output logic [DW-1:0] mul_mx,
  output logic          mul_vld,
  output logic          mul_tag,
  output logic          mul_busy
);

  localparam int CW = $clog2(DW + 2);

  mul_state_e      r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [2*DW-1:0] r_mcand, r_acc, w_sprod;
  logic [DW:0]     r_mplr, w_ax, w_bx, w_amag, w_bmag;
  logic            r_sign, r_tq, r_vld, r_tag, w_busy;
  logic [1:0]      r_fn;
  logic [DW-1:0]   r_mx, w_res;

  // Extend operands, take magnitudes; apply sign and select the result half
  always_comb begin
    w_ax = {ext_sign(mul_fn, 1'b0) & opa_of[DW-1], opa_of};
    w_bx = {ext_sign(mul_fn, 1'b1) & opb_of[DW-1], opb_of};
    if (w_ax[DW]) w_amag = ~w_ax + {{DW{1'b0}}, 1'b1};
    else          w_amag = w_ax;
    if (w_bx[DW]) w_bmag = ~w_bx + {{DW{1'b0}}, 1'b1};
    else          w_bmag = w_bx;
    if (r_sign) w_sprod = ~r_acc + {{(2*DW-1){1'b0}}, 1'b1};
    else        w_sprod = r_acc;
    if (r_fn == MUL_LO) w_res = w_sprod[DW-1:0];
    else                w_res = w_sprod[2*DW-1:DW];
  end

  // FSM state register
  always_ff @(posedge gclk or posedge grst) begin
    if (grst)      r_state <= IDLE;
    else if (dena) r_state <= w_state_nxt;
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (mul_stb) w_state_nxt = RUN;
            else         w_state_nxt = IDLE;
      RUN:  if (r_cnt == CW'(1)) w_state_nxt = DONE;
            else                 w_state_nxt = RUN;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_busy = 1'b0;
    case (r_state)
      IDLE:    w_busy = 1'b0;
      RUN:     w_busy = 1'b1;
      DONE:    w_busy = 1'b1;
      default: w_busy = 1'b0;
    endcase
  end

  // Datapath: operand latch, shift-add iteration, result load
  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      r_cnt   <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_acc   <= '0;
      r_sign  <= 1'b0;
      r_fn    <= 2'b00;
      r_tq    <= 1'b0;
      r_mx    <= '0;
      r_vld   <= 1'b0;
      r_tag   <= 1'b0;
    end else if (dena) begin
      case (r_state)
        IDLE: begin
          r_vld <= 1'b0;
          if (mul_stb) begin
            r_mcand <= {{(DW-1){1'b0}}, w_amag};
            r_mplr  <= w_bmag;
            r_acc   <= '0;
            r_sign  <= w_ax[DW] ^ w_bx[DW];
            r_fn    <= mul_fn;
            r_tq    <= gpha;
            r_cnt   <= CW'(DW + 1);
          end
        end
        RUN: begin
          if (r_mplr[0]) r_acc <= r_acc + r_mcand;
          r_mcand <= r_mcand << 1;
          r_mplr  <= r_mplr >> 1;
          r_cnt   <= r_cnt - CW'(1);
        end
        DONE: begin
          r_mx  <= w_res;
          r_tag <= r_tq;
          r_vld <= 1'b1;
        end
        default: r_vld <= 1'b0;
      endcase
    end
  end

  assign mul_mx   = r_mx;
  assign mul_vld  = r_vld;
  assign mul_tag  = r_tag;
  assign mul_busy = w_busy;

endmodule

// File: rtl/aemb2_mulx.sv
// AEMB2 execute-stage multiplier: pipelined, iterative or absent, chosen by
// AEMB_MUL. Result is qualified by mul_vld and carries the issuing thread tag.
module aemb2_mulx
  import aemb2_mul_pkg::*;
#(
  parameter int AEMB_MUL = 1,
  parameter int DW       = 32,
  parameter int LAT      = 2
) (
  input  logic          gclk,
  input  logic          grst,
  input  logic          dena,
  input  logic          gpha,
  input  logic          mul_stb,
  input  logic [1:0]    mul_fn,
  input  logic [DW-1:0] opa_of,
  input  logic [DW-1:0] opb_of,
  output logic [DW-1:0] mul_mx,
  output logic          mul_vld,
  output logic          mul_tag,
  output logic          mul_busy
);

  generate
    if (AEMB_MUL == 1) begin : g_pipe
      logic [DW:0]              w_ax, w_bx;
      logic [2*DW-1:0]          w_prod;
      logic [DW-1:0]            w_res;
      logic [LAT-1:0]           r_vld, r_tag;
      logic [LAT-1:0][DW-1:0]   r_dat;

      // Product truncated to 2DW bits; anything above is discarded anyway
      always_comb begin
        w_ax   = {ext_sign(mul_fn, 1'b0) & opa_of[DW-1], opa_of};
        w_bx   = {ext_sign(mul_fn, 1'b1) & opb_of[DW-1], opb_of};
        w_prod = {{(DW-1){w_ax[DW]}}, w_ax} * {{(DW-1){w_bx[DW]}}, w_bx};
        if (mul_fn == MUL_LO) w_res = w_prod[DW-1:0];
        else                  w_res = w_prod[2*DW-1:DW];
      end

      // Valid pipe; data/tag only move behind a valid so bubbles hold the result
      always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
          r_vld <= '0;
          r_tag <= '0;
          r_dat <= '0;
        end else if (dena) begin
          r_vld[0] <= mul_stb;
          if (mul_stb) begin
            r_dat[0] <= w_res;
            r_tag[0] <= gpha;
          end
          for (int k = 1; k < LAT; k++) begin
            r_vld[k] <= r_vld[k-1];
            if (r_vld[k-1]) begin
              r_dat[k] <= r_dat[k-1];
              r_tag[k] <= r_tag[k-1];
            end
          end
        end
      end

      assign mul_mx   = r_dat[LAT-1];
      assign mul_vld  = r_vld[LAT-1];
      assign mul_tag  = r_tag[LAT-1];
      assign mul_busy = 1'b0;
    end else if (AEMB_MUL == 2) begin : g_iter
      aemb2_mulx_iter #(.DW(DW)) u_iter (
        .gclk     (gclk),
        .grst     (grst),
        .dena     (dena),
        .gpha     (gpha),
        .mul_stb  (mul_stb),
        .mul_fn   (mul_fn),
        .opa_of   (opa_of),
        .opb_of   (opb_of),
        .mul_mx   (mul_mx),
        .mul_vld  (mul_vld),
        .mul_tag  (mul_tag),
        .mul_busy (mul_busy)
      );
    end else begin : g_none
      assign mul_mx   = '0;
      assign mul_vld  = 1'b0;
      assign mul_tag  = 1'b0;
      assign mul_busy = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_aemb2_mulx.sv
// Directed bench for aemb2_mulx: pipelined (DW=32, LAT=2), iterative (DW=32 and
// DW=8) and absent builds, all sharing clock, reset, enable and thread phase.
module tb_aemb2_mulx;

  logic gclk = 1'b0;
  logic grst, dena, gpha;

  logic        p_stb;  logic [1:0] p_fn;  logic [31:0] p_a, p_b;
  logic [31:0] p_mx;   logic p_vld, p_tag, p_busy;
  logic [31:0] n_mx;   logic n_vld, n_tag, n_busy;
  logic        t_stb;  logic [1:0] t_fn;  logic [31:0] t_a, t_b;
  logic [31:0] t_mx;   logic t_vld, t_tag, t_busy;
  logic        e_stb;  logic [1:0] e_fn;  logic [7:0]  e_a, e_b;
  logic [7:0]  e_mx;   logic e_vld, e_tag, e_busy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 gclk = ~gclk;

  aemb2_mulx #(.AEMB_MUL(1), .DW(32), .LAT(2)) u_pipe (
    .gclk(gclk), .grst(grst), .dena(dena), .gpha(gpha), .mul_stb(p_stb), .mul_fn(p_fn),
    .opa_of(p_a), .opb_of(p_b), .mul_mx(p_mx), .mul_vld(p_vld), .mul_tag(p_tag), .mul_busy(p_busy));

  aemb2_mulx #(.AEMB_MUL(0), .DW(32), .LAT(2)) u_none (
    .gclk(gclk), .grst(grst), .dena(dena), .gpha(gpha), .mul_stb(p_stb), .mul_fn(p_fn),
    .opa_of(p_a), .opb_of(p_b), .mul_mx(n_mx), .mul_vld(n_vld), .mul_tag(n_tag), .mul_busy(n_busy));

  aemb2_mulx #(.AEMB_MUL(2), .DW(32), .LAT(2)) u_it32 (
    .gclk(gclk), .grst(grst), .dena(dena), .gpha(gpha), .mul_stb(t_stb), .mul_fn(t_fn),
    .opa_of(t_a), .opb_of(t_b), .mul_mx(t_mx), .mul_vld(t_vld), .mul_tag(t_tag), .mul_busy(t_busy));

  aemb2_mulx #(.AEMB_MUL(2), .DW(8), .LAT(2)) u_it8 (
    .gclk(gclk), .grst(grst), .dena(dena), .gpha(gpha), .mul_stb(e_stb), .mul_fn(e_fn),
    .opa_of(e_a), .opb_of(e_b), .mul_mx(e_mx), .mul_vld(e_vld), .mul_tag(e_tag), .mul_busy(e_busy));

  localparam int NV = 10;
  logic [1:0]  v_fn [NV] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b00};
  logic [31:0] v_a  [NV] = '{32'd3, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                            32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h12345678};
  logic [31:0] v_b  [NV] = '{32'd5, 32'd9, 32'd2, 32'd2, 32'd2,
                            32'd2, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000010};
  logic [31:0] v_r  [NV] = '{32'd15, 32'd63, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF,
                            32'h00000001, 32'h40000000, 32'hFFFFFFFE, 32'h80000000, 32'h23456780};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  initial begin
    int seen;
    grst = 1'b1; dena = 1'b1; gpha = 1'b0;
    p_stb = 1'b0; p_fn = 2'b00; p_a = 32'd0; p_b = 32'd0;
    t_stb = 1'b0; t_fn = 2'b00; t_a = 32'd0; t_b = 32'd0;
    e_stb = 1'b0; e_fn = 2'b00; e_a = 8'd0;  e_b = 8'd0;
    tick(); tick();
    chk("rst_p_mx", 64'(p_mx), 64'd0);
    chk("rst_p_vld", 64'(p_vld), 64'd0);
    chk("rst_p_tag", 64'(p_tag), 64'd0);
    chk("rst_p_busy", 64'(p_busy), 64'd0);
    chk("rst_t_mx", 64'(t_mx), 64'd0);
    chk("rst_t_vld", 64'(t_vld), 64'd0);
    chk("rst_t_busy", 64'(t_busy), 64'd0);
    chk("rst_e_vld", 64'(e_vld), 64'd0);
    grst = 1'b0;
    tick();

    // Pipelined back-to-back issues: result of issue i is on the outputs after edge i+1
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) begin
        p_stb = 1'b1; p_fn = v_fn[i]; p_a = v_a[i]; p_b = v_b[i]; gpha = i[0];
      end else begin
        p_stb = 1'b0;
      end
      tick();
      if (i >= 1) begin
        chk($sformatf("pipe_vld_%0d", i - 1), 64'(p_vld), 64'd1);
        chk($sformatf("pipe_mx_%0d", i - 1), 64'(p_mx), 64'(v_r[i-1]));
        chk($sformatf("pipe_tag_%0d", i - 1), 64'(p_tag), 64'((i - 1) & 1));
      end
    end
    tick();
    chk("pipe_bubble_vld", 64'(p_vld), 64'd0);
    chk("pipe_bubble_mx", 64'(p_mx), 64'(v_r[NV-1]));
    chk("pipe_busy", 64'(p_busy), 64'd0);
    chk("none_mx", 64'(n_mx), 64'd0);
    chk("none_vld", 64'(n_vld), 64'd0);
    chk("none_tag", 64'(n_tag), 64'd0);
    chk("none_busy", 64'(n_busy), 64'd0);

    // Stall: 5 disabled cycles after issue; strobe during the stall is dropped
    gpha = 1'b1; p_stb = 1'b1; p_fn = 2'b00; p_a = 32'd6; p_b = 32'd7;
    tick();
    dena = 1'b0; p_a = 32'd100; p_b = 32'd100;
    repeat (5) tick();
    chk("stall_vld_hold", 64'(p_vld), 64'd0);
    chk("stall_mx_hold", 64'(p_mx), 64'(v_r[NV-1]));
    dena = 1'b1; p_stb = 1'b0; gpha = 1'b0;
    tick();
    chk("stall_vld", 64'(p_vld), 64'd1);
    chk("stall_mx", 64'(p_mx), 64'd42);
    chk("stall_tag", 64'(p_tag), 64'd1);
    tick();
    chk("stall_stb_ignored", 64'(p_vld), 64'd0);
    chk("stall_mx_keep", 64'(p_mx), 64'd42);

    // Pipelined reset mid-operation
    gpha = 1'b1; p_stb = 1'b1; p_a = 32'd9; p_b = 32'd9;
    tick();
    p_stb = 1'b0; grst = 1'b1;
    #1;
    chk("prst_mx", 64'(p_mx), 64'd0);
    chk("prst_vld", 64'(p_vld), 64'd0);
    chk("prst_tag", 64'(p_tag), 64'd0);
    grst = 1'b0;
    tick(); tick();
    chk("prst_no_vld", 64'(p_vld), 64'd0);
    chk("prst_mx_after", 64'(p_mx), 64'd0);

    // Iterative DW=32: fn 01, 0x80000000^2, result after DW+3 cycles
    gpha = 1'b1; t_stb = 1'b1; t_fn = 2'b01; t_a = 32'h80000000; t_b = 32'h80000000;
    tick();
    t_stb = 1'b0; gpha = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      chk($sformatf("it32_busy_c%0d", c), 64'(t_busy), 64'd1);
      chk($sformatf("it32_novld_c%0d", c), 64'(t_vld), 64'd0);
      if (c == 10) begin
        t_stb = 1'b1; t_fn = 2'b00; t_a = 32'd3; t_b = 32'd3;
      end else begin
        t_stb = 1'b0;
      end
      tick();
    end
    chk("it32_vld", 64'(t_vld), 64'd1);
    chk("it32_mx", 64'(t_mx), 64'h40000000);
    chk("it32_tag", 64'(t_tag), 64'd1);
    chk("it32_busy_done", 64'(t_busy), 64'd0);
    tick();
    chk("it32_vld_one", 64'(t_vld), 64'd0);
    chk("it32_idle", 64'(t_busy), 64'd0);
    chk("it32_mx_keep", 64'(t_mx), 64'h40000000);

    // Iterative reset during RUN
    gpha = 1'b1; t_stb = 1'b1; t_fn = 2'b11; t_a = 32'hFFFFFFFF; t_b = 32'hFFFFFFFF;
    tick();
    t_stb = 1'b0;
    repeat (5) tick();
    chk("irst_busy_before", 64'(t_busy), 64'd1);
    grst = 1'b1;
    #1;
    chk("irst_busy", 64'(t_busy), 64'd0);
    chk("irst_vld", 64'(t_vld), 64'd0);
    chk("irst_mx", 64'(t_mx), 64'd0);
    chk("irst_tag", 64'(t_tag), 64'd0);
    grst = 1'b0; gpha = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (t_vld) seen = 1;
    end
    chk("irst_no_result", 64'(seen), 64'd0);
    chk("irst_idle", 64'(t_busy), 64'd0);

    // Iterative DW=8: 0x7F*0x7F low, DONE-cycle strobe dropped, then high half
    e_stb = 1'b1; e_fn = 2'b00; e_a = 8'h7F; e_b = 8'h7F;
    tick();
    e_stb = 1'b0;
    chk("it8_busy1", 64'(e_busy), 64'd1);
    repeat (8) tick();
    chk("it8_novld_c9", 64'(e_vld), 64'd0);
    tick();
    chk("it8_busy_done", 64'(e_busy), 64'd1);
    chk("it8_novld_c10", 64'(e_vld), 64'd0);
    e_stb = 1'b1;
    tick();
    e_stb = 1'b0;
    chk("it8_lo_vld", 64'(e_vld), 64'd1);
    chk("it8_lo_mx", 64'(e_mx), 64'h01);
    chk("it8_done_stb_ignored", 64'(e_busy), 64'd0);
    tick();
    chk("it8_vld_one", 64'(e_vld), 64'd0);
    gpha = 1'b1; e_stb = 1'b1; e_fn = 2'b01;
    tick();
    e_stb = 1'b0; gpha = 1'b0;
    chk("it8_second_accepted", 64'(e_busy), 64'd1);
    repeat (9) tick();
    chk("it8_hi_novld_c10", 64'(e_vld), 64'd0);
    tick();
    chk("it8_hi_vld", 64'(e_vld), 64'd1);
    chk("it8_hi_mx", 64'(e_mx), 64'h3F);
    chk("it8_hi_tag", 64'(e_tag), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
